draw_bg_fade: RTL and testbench

//  Parametrised background generator with three selectable screens (IDLE, SINGLE, MULTI).

---
 rtl/draw_bg_pkg.sv | 36 +++
 rtl/draw_bg_fade_if.sv | 25 ++
 rtl/draw_bg_fade_ctrl.sv | 92 +++++++++
 rtl/draw_bg_fade.sv | 112 +++++++++++
 tb/tb_draw_bg_fade.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/draw_bg_pkg.sv
// Shared types, colour constants and brightness scaling for the background/fade block.
package draw_bg_pkg;

   typedef enum logic [1:0] {SCR_IDLE = 2'd0, SCR_SINGLE = 2'd1, SCR_MULTI = 2'd2, SCR_RSVD = 2'd3} screen_t;
   typedef enum logic [1:0] {SHOW = 2'd0, FADE_OUT = 2'd1, FADE_IN = 2'd2} fade_state_t;

   localparam logic [11:0] COL_BLACK   = 12'h000;
   localparam logic [11:0] COL_WHITE   = 12'hfff;
   localparam logic [11:0] COL_FIELD_L = 12'h02f;
   localparam logic [11:0] COL_FIELD_R = 12'h20f;
   localparam logic [11:0] COL_GREY    = 12'h555;
   localparam logic [11:0] COL_YELLOW  = 12'hff0;
   localparam logic [11:0] COL_RED     = 12'hf00;
   localparam logic [11:0] COL_GREEN   = 12'h0f0;

   localparam logic [4:0] LEVEL_MAX = 5'd16;

   typedef struct packed {
      logic [10:0] vcount;
      logic [10:0] hcount;
      logic        vsync;
      logic        hsync;
      logic        vblnk;
      logic        hblnk;
   } timing_t;

   // Per-channel (c*level)>>4; level 16 passes the colour unchanged.
   function automatic logic [11:0] scale_rgb(input logic [11:0] rgb, input logic [4:0] level);
      logic [8:0] p_r, p_g, p_b;
      p_r = {5'd0, rgb[11:8]} * {4'd0, level};
      p_g = {5'd0, rgb[7:4]}  * {4'd0, level};
      p_b = {5'd0, rgb[3:0]}  * {4'd0, level};
      return {4'(p_r >> 4), 4'(p_g >> 4), 4'(p_b >> 4)};
   endfunction

endpackage

// File: rtl/draw_bg_fade_if.sv
// VGA timing bundle without colour (from the timing generator) and with colour (rgb pipeline).
interface vga_if_no_rgb;
   logic [10:0] vcount;
   logic [10:0] hcount;
   logic        vsync;
   logic        hsync;
   logic        vblnk;
   logic        hblnk;

   modport master (output vcount, hcount, vsync, hsync, vblnk, hblnk);
   modport bg_in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk);
endinterface

interface vga_if;
   logic [10:0] vcount;
   logic [10:0] hcount;
   logic        vsync;
   logic        hsync;
   logic        vblnk;
   logic        hblnk;
   logic [11:0] rgb;

   modport out  (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
   modport sink (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_bg_fade_ctrl.sv
// Fade controller: frame tick detect, frame divider, fade FSM, target/level/cur_screen registers.
module bg_fade_ctrl
   import draw_bg_pkg::*;
#(
   parameter int FADE_FRAMES = 2
) (
   input  logic       clk65MHz,
   input  logic       rst,
   input  logic       vblnk,
   input  logic [1:0] screen_sel,
   output screen_t    cur_screen,
   output logic [4:0] level,
   output logic       fade_busy
);

   localparam int             FCNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
   localparam logic [FCNT_W-1:0] FMAX = FCNT_W'(FADE_FRAMES - 1);

   fade_state_t       state, state_nxt;
   screen_t           target, target_nxt, cur_nxt;
   logic [4:0]        level_nxt;
   logic [FCNT_W-1:0] fcnt, fcnt_nxt;
   logic              vblnk_d, tick, step;

   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         vblnk_d    <= 1'b0;
         fcnt       <= '0;
         state      <= SHOW;
         target     <= SCR_IDLE;
         level      <= LEVEL_MAX;
         cur_screen <= SCR_IDLE;
      end else begin
         vblnk_d    <= vblnk;
         fcnt       <= fcnt_nxt;
         state      <= state_nxt;
         target     <= target_nxt;
         level      <= level_nxt;
         cur_screen <= cur_nxt;
      end
   end

   // cur_screen/level move only on a tick, which lands inside vertical blanking.
   always_comb begin
      tick       = vblnk & ~vblnk_d;
      step       = tick && (fcnt == FMAX);
      target_nxt = (screen_sel != 2'd3) ? screen_t'(screen_sel) : target;
      state_nxt  = state;
      level_nxt  = level;
      cur_nxt    = cur_screen;
      fcnt_nxt   = fcnt;
      if (tick) begin
         fcnt_nxt = step ? '0 : fcnt + FCNT_W'(1);
         case (state)
            SHOW: begin
               if (target != cur_screen) begin
                  state_nxt = FADE_OUT;
                  fcnt_nxt  = '0;
               end
            end
            FADE_OUT: begin
               if (target == cur_screen) begin
                  state_nxt = FADE_IN;
                  fcnt_nxt  = '0;
               end else if (step) begin
                  if (level <= 5'd1) begin
                     level_nxt = 5'd0;
                     cur_nxt   = target;
                     state_nxt = FADE_IN;
                  end else begin
                     level_nxt = level - 5'd1;
                  end
               end
            end
            FADE_IN: begin
               if (step) begin
                  if (level >= 5'd15) begin
                     level_nxt = LEVEL_MAX;
                     state_nxt = (target == cur_screen) ? SHOW : FADE_OUT;
                  end else begin
                     level_nxt = level + 5'd1;
                  end
               end
            end
            default: state_nxt = SHOW;
         endcase
      end
   end

   assign fade_busy = (state != SHOW);

endmodule

// File: rtl/draw_bg_fade.sv
// Background generator (IDLE/SINGLE/MULTI) with frame-synchronous fade, 2-stage pipeline.
// Define DRAW_BG_DASHED_NET_EN for a dashed centre net; default build draws a solid net.
module draw_bg_fade
   import draw_bg_pkg::*;
#(
   parameter int HOR_PIXELS  = 1024,
   parameter int VER_PIXELS  = 768,
   parameter int H_START     = 80,
   parameter int H_PIXEL_NO  = 863,
   parameter int V_START     = 80,
   parameter int V_PIXEL_NO  = 607,
   parameter int BAR_TOP     = 51,
   parameter int BAR_BOT     = 717,
   parameter int NET_X0      = 508,
   parameter int NET_W       = 9,
   parameter int NET_DASH    = 16,
   parameter int FADE_FRAMES = 2
) (
   input  logic        clk65MHz,
   input  logic        rst,
   input  logic [1:0]  screen_sel,
   vga_if_no_rgb.bg_in timing_if,
   vga_if.out          draw_bg_if,
   output logic [1:0]  cur_screen,
   output logic        fade_busy
);

   localparam logic [10:0] H_LAST = 11'(HOR_PIXELS - 1);
   localparam logic [10:0] V_LAST = 11'(VER_PIXELS - 1);
   localparam logic [10:0] WIN_H0 = 11'(H_START);
   localparam logic [10:0] WIN_H1 = 11'(H_PIXEL_NO);
   localparam logic [10:0] WIN_V0 = 11'(V_START);
   localparam logic [10:0] WIN_V1 = 11'(V_PIXEL_NO);
   localparam logic [10:0] BAR_T  = 11'(BAR_TOP);
   localparam logic [10:0] BAR_B  = 11'(BAR_BOT);
   localparam logic [10:0] NET_L  = 11'(NET_X0);
   localparam logic [10:0] NET_R  = 11'(NET_X0 + NET_W);
   localparam int          DASH_SH = $clog2(NET_DASH);
`ifdef DRAW_BG_DASHED_NET_EN
   localparam bit DASHED = 1'b1;
`else
   localparam bit DASHED = 1'b0;
`endif

   screen_t     cur_scr;
   logic [4:0]  level;
   timing_t     tin, s1_t, s2_t;
   logic [11:0] base_rgb, s1_rgb, s2_rgb;
   logic        in_net, net_on;

   bg_fade_ctrl #(.FADE_FRAMES(FADE_FRAMES)) u_ctrl (
      .clk65MHz   (clk65MHz),
      .rst        (rst),
      .vblnk      (timing_if.vblnk),
      .screen_sel (screen_sel),
      .cur_screen (cur_scr),
      .level      (level),
      .fade_busy  (fade_busy)
   );

   assign cur_screen = cur_scr;
   assign tin = {timing_if.vcount, timing_if.hcount, timing_if.vsync,
                 timing_if.hsync, timing_if.vblnk, timing_if.hblnk};

   // Dash phase is a bit of vcount because NET_DASH is a power of two.
   always_comb begin
      in_net   = (tin.hcount >= NET_L) && (tin.hcount < NET_R);
      net_on   = in_net && (!DASHED || !tin.vcount[DASH_SH]);
      base_rgb = COL_BLACK;
      if (!(tin.vblnk || tin.hblnk)) begin
         case (cur_scr)
            SCR_IDLE: begin
               if (tin.vcount == 11'd0)                               base_rgb = COL_YELLOW;
               else if (tin.vcount == V_LAST)                         base_rgb = COL_RED;
               else if (tin.hcount == 11'd0 || tin.hcount == H_LAST)  base_rgb = COL_GREEN;
               else if (tin.hcount >= WIN_H0 && tin.hcount <= WIN_H1 &&
                        tin.vcount >= WIN_V0 && tin.vcount <= WIN_V1) base_rgb = COL_GREY;
               else                                                   base_rgb = COL_FIELD_L;
            end
            SCR_SINGLE, SCR_MULTI: begin
               if (tin.vcount < BAR_T || tin.vcount > BAR_B || net_on) base_rgb = COL_WHITE;
               else if (cur_scr == SCR_MULTI && tin.hcount >= NET_R)   base_rgb = COL_FIELD_R;
               else                                                    base_rgb = COL_FIELD_L;
            end
            default: base_rgb = COL_BLACK;
         endcase
      end
   end

   always_ff @(posedge clk65MHz) begin
      if (rst) begin
         s1_t   <= '0;
         s1_rgb <= '0;
         s2_t   <= '0;
         s2_rgb <= '0;
      end else begin
         s1_t   <= tin;
         s1_rgb <= base_rgb;
         s2_t   <= s1_t;
         s2_rgb <= scale_rgb(s1_rgb, level);
      end
   end

   assign draw_bg_if.vcount = s2_t.vcount;
   assign draw_bg_if.hcount = s2_t.hcount;
   assign draw_bg_if.vsync  = s2_t.vsync;
   assign draw_bg_if.hsync  = s2_t.hsync;
   assign draw_bg_if.vblnk  = s2_t.vblnk;
   assign draw_bg_if.hblnk  = s2_t.hblnk;
   assign draw_bg_if.rgb    = s2_rgb;

endmodule

// File: tb/tb_draw_bg_fade.sv
// Scoreboard bench for draw_bg_fade: short synthetic frames, one vblnk pulse per frame.
module tb_draw_bg_fade;

   logic       clk65MHz = 1'b0;
   logic       rst;
   logic [1:0] screen_sel;
   logic [1:0] cur_screen;
   logic       fade_busy;

   vga_if_no_rgb tim ();
   vga_if        vout ();

   draw_bg_fade dut (
      .clk65MHz   (clk65MHz),
      .rst        (rst),
      .screen_sel (screen_sel),
      .timing_if  (tim),
      .draw_bg_if (vout),
      .cur_screen (cur_screen),
      .fade_busy  (fade_busy)
   );

   always #5 clk65MHz = ~clk65MHz;

`ifdef DRAW_BG_DASHED_NET_EN
   localparam bit DASHED = 1'b1;
`else
   localparam bit DASHED = 1'b0;
`endif

   typedef struct {
      logic [25:0] t;
      logic [11:0] rgb;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;

   int px_h [9] = '{0, 500, 40, 0,   1023, 300, 512, 512, 700};
   int px_v [9] = '{0, 300, 40, 400, 400,  767, 64,  80,  400};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] ref_pix(input int h, input int v, input logic blank,
                                           input int scr, input int lvl);
      int c, r, g, b;
      if (blank) c = 'h000;
      else if (scr == 0) begin
         if (v == 0)                                          c = 'hff0;
         else if (v == 767)                                   c = 'hf00;
         else if (h == 0 || h == 1023)                        c = 'h0f0;
         else if (h >= 80 && h <= 863 && v >= 80 && v <= 607) c = 'h555;
         else                                                 c = 'h02f;
      end else begin
         if (v < 51 || v > 717)                                             c = 'hfff;
         else if (h >= 508 && h < 517 && (!DASHED || ((v / 16) % 2) == 0))  c = 'hfff;
         else if (scr == 2 && h >= 517)                                     c = 'h20f;
         else                                                               c = 'h02f;
      end
      r = (((c >> 8) & 15) * lvl) >> 4;
      g = (((c >> 4) & 15) * lvl) >> 4;
      b = ((c & 15) * lvl) >> 4;
      return 12'((r << 8) | (g << 4) | b);
   endfunction

   // One pixel clock: drive, push expectation, compare the output of two cycles ago.
   task automatic cyc(input int h, input int v, input logic vb, input logic hb,
                      input int scr, input int lvl);
      exp_t e, o;
      logic [10:0] hh, vv;
      hh = 11'(h);
      vv = 11'(v);
      tim.hcount = hh;
      tim.vcount = vv;
      tim.vsync  = vv[0];
      tim.hsync  = hh[1];
      tim.vblnk  = vb;
      tim.hblnk  = hb;
      e.t   = {vv, hh, vv[0], hh[1], vb, hb};
      e.rgb = ref_pix(h, v, vb | hb, scr, lvl);
      sb.push_back(e);
      @(negedge clk65MHz);
      if (sb.size() == 3) begin
         o = sb.pop_front();
         chk("timing", {vout.vcount, vout.hcount, vout.vsync, vout.hsync, vout.vblnk, vout.hblnk}, o.t);
         chk("rgb", vout.rgb, o.rgb);
      end
      @(posedge clk65MHz);
      #1;
   endtask

   task automatic frame(input int scr, input int lvl, input logic busy, input bit do_tick = 1'b1);
      chk("cur_screen", cur_screen, scr);
      chk("fade_busy", fade_busy, busy);
      for (int i = 0; i < 9; i++) cyc(px_h[i], px_v[i], 1'b0, 1'b0, scr, lvl);
      cyc(5, 5, 1'b0, 1'b1, scr, lvl);
      if (do_tick) begin
         cyc(0, 770, 1'b1, 1'b1, scr, lvl);
         cyc(0, 771, 1'b1, 1'b1, scr, lvl);
         cyc(0, 0, 1'b0, 1'b1, scr, lvl);
      end
   endtask

   // Full fade: 32 ticks down to level 0, screen swap, 32 ticks back up, then SHOW.
   task automatic fade_full(input int from, input int to);
      logic [1:0] sel;
      sel = 2'(to);
      screen_sel = sel;
      frame(from, 16, 1'b0);
      for (int j = 0; j <= 64; j++) begin
         if (j < 32) frame(from, 16 - j / 2, 1'b1);
         else        frame(to, (j - 32) / 2, j < 64);
      end
   endtask

   task automatic reset_pulse(input int cycles);
      rst = 1'b1;
      tim.hcount = 11'd100;
      tim.vcount = 11'd100;
      tim.vsync  = 1'b1;
      tim.hsync  = 1'b1;
      tim.vblnk  = 1'b0;
      tim.hblnk  = 1'b0;
      repeat (cycles) @(posedge clk65MHz);
      #1;
      chk("rst_rgb", vout.rgb, 12'h000);
      chk("rst_timing", {vout.vcount, vout.hcount, vout.vsync, vout.hsync, vout.vblnk, vout.hblnk}, 26'd0);
      chk("rst_cur_screen", cur_screen, 2'd0);
      chk("rst_fade_busy", fade_busy, 1'b0);
      rst = 1'b0;
      sb.delete();
   endtask

   initial begin
      screen_sel = 2'd0;
      reset_pulse(3);

      // steady IDLE frames
      repeat (3) frame(0, 16, 1'b0);

      // IDLE -> SINGLE full fade
      fade_full(0, 1);

      // SINGLE -> MULTI, reversed back to SINGLE at level 6
      screen_sel = 2'd2;
      frame(1, 16, 1'b0);
      for (int j = 0; j <= 20; j++) begin
         if (j == 20) screen_sel = 2'd1;
         frame(1, 16 - j / 2, 1'b1);
      end
      for (int k = 21; k <= 41; k++) frame(1, 6 + (k - 21) / 2, k < 41);

      // reserved code is ignored
      screen_sel = 2'd3;
      repeat (3) frame(1, 16, 1'b0);

      // reset in the middle of FADE_IN at level 5
      screen_sel = 2'd0;
      frame(1, 16, 1'b0);
      for (int j = 0; j <= 41; j++) begin
         if (j < 32) frame(1, 16 - j / 2, 1'b1);
         else        frame(0, (j - 32) / 2, 1'b1);
      end
      frame(0, 5, 1'b1, 1'b0);
      reset_pulse(1);
      repeat (2) frame(0, 16, 1'b0);

      // IDLE -> MULTI
      fade_full(0, 2);
      frame(2, 16, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
